// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Round-robin arbiter sharing one synchronous sprite ROM read port between
//   NREQ drawing requesters (HUD bar, slot icons, cursor overlay). Grants are
//   registered, and a one-hot tag pipe matched to the ROM latency routes each
//   returned colour back to the requester that issued the read.
//
// Ports
//   Clk        system clock, all state on the rising edge
//   Reset      synchronous active-high reset
//   req        per-requester read request (bit i = requester i)
//   req_addr   packed request addresses, slice i = req_addr[i*ADDR_W +: ADDR_W]
//   gnt        one-hot registered grant pulse
//   rom_addr   registered address to the ROM read port
//   rom_data   ROM read data
//   rsp_valid  one-hot, rom_data belongs to requester i this cycle
//   rsp_data   combinational copy of rom_data
module sprite_rom_arbiter #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  output logic [NREQ-1:0]          gnt,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_data
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PtrW-1:0] ptr;
  logic [PtrW-1:0] win;
  logic [PtrW-1:0] ptr_next;
  logic            found;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] tag_pipe [ROM_LAT];

  // A requester granted this cycle is masked so a held req is not granted twice.
  assign eligible = req & ~gnt;

  // Scan ptr, ptr+1, ... (mod NREQ) and take the first eligible requester.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found && eligible[idx[PtrW-1:0]]) begin
        found = 1'b1;
        win   = idx[PtrW-1:0];
      end
    end
  end

  assign ptr_next = (win == PtrW'(NREQ - 1)) ? '0 : win + 1'b1;

  // The gnt register is the issue stage (address presented to the ROM); the
  // tag pipe then delays that one-hot by ROM_LAT to line up with rom_data.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      gnt      <= '0;
      rom_addr <= '0;
      ptr      <= '0;
      for (int unsigned k = 0; k < ROM_LAT; k++) begin
        tag_pipe[k] <= '0;
      end
    end else begin
      if (found) begin
        gnt      <= NREQ'(1) << win;
        rom_addr <= req_addr[win*ADDR_W +: ADDR_W];
        ptr      <= ptr_next;
      end else begin
        gnt <= '0;
      end
      tag_pipe[0] <= gnt;
      for (int unsigned k = 1; k < ROM_LAT; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  assign rsp_valid = tag_pipe[ROM_LAT-1];
  assign rsp_data  = rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter
//   Directed scenarios plus randomized requester traffic, checked against a
//   cycle-level reference model of round-robin arbitration and a response
//   scoreboard. The bench ROM returns {zeros, addr} one cycle after rom_addr.
module tb_sprite_rom_arbiter;

  localparam int NREQ    = 3;
  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 24;
  localparam int ROM_LAT = 1;

  logic                   Clk;
  logic                   Reset;
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        gnt;
  logic [ADDR_W-1:0]      rom_addr;
  logic [DATA_W-1:0]      rom_data;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_data;

  sprite_rom_arbiter #(
    .NREQ    (NREQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .ROM_LAT (ROM_LAT)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Bench ROM, one cycle latency.
  always @(posedge Clk) rom_data <= {{(DATA_W-ADDR_W){1'b0}}, rom_addr};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  typedef struct {
    int              due;
    int              idx;
    logic [ADDR_W-1:0] addr;
  } rsp_t;

  rsp_t              rspq[$];
  logic [NREQ-1:0]   m_gnt = '0;
  logic [ADDR_W-1:0] m_addr = '0;
  int                m_ptr = 0;
  int                cyc = 0;

  // Requester behaviour.
  logic              pend  [NREQ];
  logic [ADDR_W-1:0] paddr [NREQ];
  logic              cont  [NREQ];
  logic              rand_mode = 1'b0;

  // Observations of the DUT for directed scenario checks.
  logic [31:0] gseq[$];
  logic [31:0] aseq[$];
  logic [31:0] vseq[$];
  logic [31:0] rseq[$];

  // One clock: model predicts the edge from the driven inputs, then compares.
  task automatic step();
    int                w;
    int                best;
    int                d;
    logic [ADDR_W-1:0] waddr;
    logic [NREQ-1:0]   exp_v;
    logic [DATA_W-1:0] exp_d;
    rsp_t              e;
    w = -1;
    best = NREQ;
    waddr = '0;
    if (!Reset) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && !m_gnt[i]) begin
          d = (i - m_ptr + NREQ) % NREQ;
          if (d < best) begin
            best = d;
            w = i;
          end
        end
      end
      if (w >= 0) waddr = req_addr[w*ADDR_W +: ADDR_W];
    end
    @(posedge Clk);
    #1;
    cyc++;
    if (Reset) begin
      m_gnt = '0;
      m_addr = '0;
      m_ptr = 0;
      rspq.delete();
    end else if (w >= 0) begin
      m_gnt = NREQ'(1 << w);
      m_addr = waddr;
      m_ptr = (w + 1) % NREQ;
      e.due = cyc + ROM_LAT;
      e.idx = w;
      e.addr = waddr;
      rspq.push_back(e);
    end else begin
      m_gnt = '0;
    end
    exp_v = '0;
    exp_d = '0;
    if (rspq.size() > 0 && rspq[0].due == cyc) begin
      exp_v = NREQ'(1 << rspq[0].idx);
      exp_d = {{(DATA_W-ADDR_W){1'b0}}, rspq[0].addr};
      void'(rspq.pop_front());
    end
    check("gnt", 32'(gnt), 32'(m_gnt));
    check("rom_addr", 32'(rom_addr), 32'(m_addr));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    if (exp_v != '0) check("rsp_data", 32'(rsp_data), 32'(exp_d));
  endtask

  task automatic run_cycle();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = pend[i];
      req_addr[i*ADDR_W +: ADDR_W] = paddr[i];
    end
    step();
    if (gnt != '0) begin
      gseq.push_back(32'(gnt));
      aseq.push_back(32'(rom_addr));
    end
    if (rsp_valid != '0) begin
      vseq.push_back(32'(rsp_valid));
      rseq.push_back(32'(rsp_data));
    end
    for (int i = 0; i < NREQ; i++) begin
      if (m_gnt[i]) begin
        if (rand_mode) begin
          if ($urandom_range(1) == 1) paddr[i] = ADDR_W'($urandom_range(2047));
          else pend[i] = 1'b0;
        end else if (cont[i]) begin
          paddr[i] = paddr[i] + 1'b1;
        end else begin
          pend[i] = 1'b0;
        end
      end else if (rand_mode && !pend[i] && $urandom_range(2) == 0) begin
        pend[i] = 1'b1;
        paddr[i] = ADDR_W'($urandom_range(2047));
      end
    end
  endtask

  task automatic clear_obs();
    gseq.delete();
    aseq.delete();
    vseq.delete();
    rseq.delete();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    run_cycle();
    Reset = 1'b0;
  endtask

  initial begin
    int exp2[3];
    int expr[3];
    Reset = 1'b1;
    req = '0;
    req_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      paddr[i] = '0;
      cont[i] = 1'b0;
    end
    run_cycle();
    run_cycle();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    Reset = 1'b0;

    // Single request from requester 1.
    pend[1] = 1'b1;
    paddr[1] = 11'd37;
    run_cycle();
    check("t1_gnt", 32'(gnt), 32'b010);
    check("t1_addr", 32'(rom_addr), 32'd37);
    run_cycle();
    check("t1_rspv", 32'(rsp_valid), 32'b010);
    check("t1_rspd", 32'(rsp_data), 32'h25);
    run_cycle();
    run_cycle();
    check("t1_idle", 32'(gnt), 32'd0);

    // All three requesting once, from ptr=0.
    do_reset();
    clear_obs();
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b1;
    paddr[0] = 11'd100;
    paddr[1] = 11'd200;
    paddr[2] = 11'd300;
    for (int c = 0; c < 5; c++) run_cycle();
    exp2 = '{1, 2, 4};
    expr = '{32'h64, 32'hC8, 32'h12C};
    check("t2_ngnt", gseq.size(), 3);
    for (int k = 0; k < 3; k++) begin
      check("t2_gnt", (k < gseq.size()) ? gseq[k] : 32'hDEAD, exp2[k]);
      check("t2_rsp", (k < rseq.size()) ? rseq[k] : 32'hDEAD, expr[k]);
    end

    // Requesters 0 and 2 continuously for 8 cycles.
    clear_obs();
    pend[0] = 1'b1; cont[0] = 1'b1; paddr[0] = 11'd5;
    pend[2] = 1'b1; cont[2] = 1'b1; paddr[2] = 11'd6;
    for (int c = 0; c < 8; c++) run_cycle();
    pend[0] = 1'b0; cont[0] = 1'b0;
    pend[2] = 1'b0; cont[2] = 1'b0;
    run_cycle();
    run_cycle();
    check("t3_ngnt", gseq.size(), 8);
    for (int k = 0; k < 8; k++) begin
      check("t3_alt", (k < gseq.size()) ? gseq[k] : 32'hDEAD, (k % 2 == 0) ? 1 : 4);
    end

    // Requester 0 held for 6 cycles, new address on each grant.
    clear_obs();
    pend[0] = 1'b1; cont[0] = 1'b1; paddr[0] = 11'd0;
    for (int c = 0; c < 6; c++) run_cycle();
    pend[0] = 1'b0; cont[0] = 1'b0;
    run_cycle();
    run_cycle();
    check("t4_ngnt", gseq.size(), 3);
    check("t4_nrsp", rseq.size(), 3);
    for (int k = 0; k < 3; k++) begin
      check("t4_rsp", (k < rseq.size()) ? rseq[k] : 32'hDEAD, k);
    end

    // Reset the cycle after a grant discards its response.
    pend[1] = 1'b1;
    paddr[1] = 11'd55;
    run_cycle();
    check("t5_gnt", 32'(gnt), 32'b010);
    do_reset();
    check("t5_rst_rspv", 32'(rsp_valid), 32'd0);
    run_cycle();
    check("t5_norsp", 32'(rsp_valid), 32'd0);
    pend[2] = 1'b1;
    paddr[2] = 11'd77;
    run_cycle();
    check("t5_gnt2", 32'(gnt), 32'b100);
    run_cycle();
    do_reset();
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b1;
    run_cycle();
    check("t5_first", 32'(gnt), 32'b001);
    for (int c = 0; c < 4; c++) run_cycle();

    // Boundary addresses.
    clear_obs();
    pend[0] = 1'b1; paddr[0] = 11'd1199;
    pend[2] = 1'b1; paddr[2] = 11'd2047;
    for (int c = 0; c < 4; c++) run_cycle();
    check("t6_addr0", (aseq.size() > 0) ? aseq[0] : 32'hDEAD, 1199);
    check("t6_addr1", (aseq.size() > 1) ? aseq[1] : 32'hDEAD, 2047);
    check("t6_v0", (vseq.size() > 0) ? vseq[0] : 32'hDEAD, 1);
    check("t6_v1", (vseq.size() > 1) ? vseq[1] : 32'hDEAD, 4);
    check("t6_d0", (rseq.size() > 0) ? rseq[0] : 32'hDEAD, 1199);
    check("t6_d1", (rseq.size() > 1) ? rseq[1] : 32'hDEAD, 2047);

    // Randomized traffic with occasional resets.
    rand_mode = 1'b1;
    for (int c = 0; c < 600; c++) begin
      Reset = ($urandom_range(63) == 0);
      run_cycle();
    end
    Reset = 1'b0;
    rand_mode = 1'b0;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    for (int c = 0; c < 4; c++) run_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
